// File: rtl/xpb_lut_bank.sv
// xpb_lut_bank: NUM_SEG run-time loadable tables of XPB reduction constants.
// Tables are filled word-serially over a narrow load bus. RD_CH independent
// pipelined read channels return one constant per cycle each, with latency RD_LAT.
module xpb_lut_bank #(
    parameter int DATA_W  = 1024,
    parameter int SEL_W   = 5,
    parameter int NUM_SEG = 4,
    parameter int SEG_W   = 2,
    parameter int RD_CH   = 2,
    parameter int RD_LAT  = 2,
    parameter int LOAD_W  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld_start,
    input  logic [SEG_W-1:0]        ld_seg,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [LOAD_W-1:0]       ld_data,
    output logic                    ld_done,
    output logic [NUM_SEG-1:0]      tbl_ready,
    input  logic [RD_CH-1:0]        rd_valid,
    input  logic [RD_CH*SEG_W-1:0]  rd_seg,
    input  logic [RD_CH*SEL_W-1:0]  rd_sel,
    output logic [RD_CH-1:0]        rd_out_valid,
    output logic [RD_CH*DATA_W-1:0] rd_data,
    output logic [RD_CH-1:0]        rd_miss
);
    localparam int WPE     = DATA_W / LOAD_W;
    localparam int CNT_W   = (WPE > 1) ? $clog2(WPE) : 1;
    localparam int SEG_CNT = 1 << SEG_W;
    localparam int ENTRIES = 1 << SEL_W;
    localparam int ADDR_W  = SEG_W + SEL_W;

    typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_e;

    state_e              state_q;
    logic                ld_ready_q;
    logic                ld_done_q;
    logic [SEG_W-1:0]    seg_q;
    logic [CNT_W-1:0]    word_cnt_q;
    logic [SEL_W-1:0]    entry_q;
    // Full power-of-two width so any segment index is in range.
    logic [SEG_CNT-1:0]  tbl_rdy_q;
    logic [DATA_W-1:0]   stage_q;

    logic                acc;
    logic                last_word;
    logic                last_entry;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data_d;

    // Entry 0 is never stored; its storage slot simply stays unused.
    logic [DATA_W-1:0]   mem_q [SEG_CNT*ENTRIES];

    // Word acceptance and entry assembly; the final word bypasses the staging
    // register so the entry is written on the same edge it completes.
    // A word presented together with ld_start is dropped.
    always_comb begin
        acc        = (state_q == LOAD) && ld_valid && !ld_start;
        last_word  = (word_cnt_q == CNT_W'(WPE - 1));
        last_entry = &entry_q;
        wr_en      = acc && last_word;
        wr_addr    = {seg_q, entry_q};
        wr_data_d  = stage_q;
        wr_data_d[int'(word_cnt_q)*LOAD_W +: LOAD_W] = ld_data;
    end

    // Load FSM: segment/entry/word tracking, ready flags and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ld_ready_q <= 1'b0;
            ld_done_q  <= 1'b0;
            seg_q      <= '0;
            word_cnt_q <= '0;
            entry_q    <= '0;
            tbl_rdy_q  <= '0;
        end else begin
            ld_done_q <= 1'b0;
            if (ld_start) begin
                // Start or abort-and-restart; the target table is invalid until complete.
                state_q              <= LOAD;
                ld_ready_q           <= 1'b1;
                seg_q                <= ld_seg;
                word_cnt_q           <= '0;
                entry_q              <= SEL_W'(1);
                tbl_rdy_q[ld_seg]    <= 1'b0;
            end else if (acc) begin
                if (last_word) begin
                    word_cnt_q <= '0;
                    if (last_entry) begin
                        state_q          <= IDLE;
                        ld_ready_q       <= 1'b0;
                        ld_done_q        <= 1'b1;
                        tbl_rdy_q[seg_q] <= 1'b1;
                    end else begin
                        entry_q <= entry_q + SEL_W'(1);
                    end
                end else begin
                    word_cnt_q <= word_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Staging register collects the leading words of an entry (LSW first).
    always_ff @(posedge clk) begin
        if (acc) begin
            stage_q[int'(word_cnt_q)*LOAD_W +: LOAD_W] <= ld_data;
        end
    end

    // Table storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data_d;
        end
    end

    assign ld_ready  = ld_ready_q;
    assign ld_done   = ld_done_q;
    assign tbl_ready = tbl_rdy_q[NUM_SEG-1:0];

    for (genvar c = 0; c < RD_CH; c++) begin : g_ch
        logic [SEG_W-1:0]  seg_c;
        logic [SEL_W-1:0]  sel_c;
        logic              hit_c;
        logic              vld_p1_q;
        logic              miss_p1_q;
        logic              zero_p1_q;
        logic [DATA_W-1:0] raw_p1_q;
        logic [DATA_W-1:0] data_p1;

        assign seg_c = rd_seg[c*SEG_W +: SEG_W];
        assign sel_c = rd_sel[c*SEL_W +: SEL_W];
        // Pre-edge flag: a table that becomes ready on this edge still misses.
        assign hit_c = tbl_rdy_q[seg_c];

        // ---- stage p1: memory read register ----
        // Raw memory read; only requests update it so idle cycles hold the result.
        always_ff @(posedge clk) begin
            if (rd_valid[c]) begin
                raw_p1_q <= mem_q[{seg_c, sel_c}];
            end
        end

        // Read control: valid every cycle, miss/zero-mask captured per request.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p1_q  <= 1'b0;
                miss_p1_q <= 1'b0;
                zero_p1_q <= 1'b1;
            end else begin
                vld_p1_q <= rd_valid[c];
                if (rd_valid[c]) begin
                    miss_p1_q <= !hit_c;
                    zero_p1_q <= !hit_c || (sel_c == '0);
                end
            end
        end

        // Misses and entry 0 read as zero regardless of memory contents.
        assign data_p1 = zero_p1_q ? '0 : raw_p1_q;

        if (RD_LAT == 1) begin : g_lat1
            assign rd_out_valid[c]              = vld_p1_q;
            assign rd_miss[c]                   = miss_p1_q;
            assign rd_data[c*DATA_W +: DATA_W]  = data_p1;
        end else begin : g_lat2
            logic              vld_p2_q;
            logic              miss_p2_q;
            logic [DATA_W-1:0] data_p2_q;

            // ---- stage p2: output register ----
            // Output register; holds the last response while no new one arrives.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_p2_q  <= 1'b0;
                    miss_p2_q <= 1'b0;
                    data_p2_q <= '0;
                end else begin
                    vld_p2_q <= vld_p1_q;
                    if (vld_p1_q) begin
                        miss_p2_q <= miss_p1_q;
                        data_p2_q <= data_p1;
                    end
                end
            end

            assign rd_out_valid[c]              = vld_p2_q;
            assign rd_miss[c]                   = miss_p2_q;
            assign rd_data[c*DATA_W +: DATA_W]  = data_p2_q;
        end
    end

endmodule

// File: tb/tb_xpb_lut_bank.sv
// Bench for xpb_lut_bank: one RD_LAT=1 and one RD_LAT=2 instance share all
// stimulus; a reference table model predicts every read response into a
// per-instance, per-channel queue that a negedge monitor drains.
`timescale 1ns/1ps
module tb_xpb_lut_bank;
    localparam int DATA_W  = 1024;
    localparam int SEL_W   = 5;
    localparam int NUM_SEG = 4;
    localparam int SEG_W   = 2;
    localparam int RD_CH   = 2;
    localparam int LOAD_W  = 64;
    localparam int WPE     = DATA_W / LOAD_W;
    localparam int ENTRIES = 1 << SEL_W;
    localparam int TOTAL   = (ENTRIES - 1) * WPE;
    localparam int NQ      = 2 * RD_CH;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ld_start = 1'b0;
    logic [SEG_W-1:0] ld_seg = '0;
    logic ld_valid = 1'b0;
    logic [LOAD_W-1:0] ld_data = '0;
    logic [RD_CH-1:0] rd_valid = '0;
    logic [RD_CH*SEG_W-1:0] rd_seg = '0;
    logic [RD_CH*SEL_W-1:0] rd_sel = '0;

    logic                    ld_ready_w     [2];
    logic                    ld_done_w      [2];
    logic [NUM_SEG-1:0]      tbl_ready_w    [2];
    logic [RD_CH-1:0]        rd_out_valid_w [2];
    logic [RD_CH*DATA_W-1:0] rd_data_w      [2];
    logic [RD_CH-1:0]        rd_miss_w      [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        xpb_lut_bank #(
            .DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_SEG(NUM_SEG), .SEG_W(SEG_W),
            .RD_CH(RD_CH), .RD_LAT(g + 1), .LOAD_W(LOAD_W)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .ld_start(ld_start), .ld_seg(ld_seg), .ld_valid(ld_valid),
            .ld_ready(ld_ready_w[g]), .ld_data(ld_data), .ld_done(ld_done_w[g]),
            .tbl_ready(tbl_ready_w[g]),
            .rd_valid(rd_valid), .rd_seg(rd_seg), .rd_sel(rd_sel),
            .rd_out_valid(rd_out_valid_w[g]), .rd_data(rd_data_w[g]), .rd_miss(rd_miss_w[g])
        );
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [DATA_W-1:0] ref_mem [NUM_SEG][ENTRIES];
    logic [NUM_SEG-1:0] ref_rdy = '0;
    logic [DATA_W-1:0] m_buf [ENTRIES];
    bit m_loading = 1'b0;
    int m_seg = 0;
    int m_widx = 0;
    bit exp_done = 1'b0;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              miss;
        logic [31:0]       due;
    } exp_t;
    exp_t sb [NQ][$];

    // Read stimulus control: 0 none, 1 random, 2 forced values below
    int rd_mode = 0;
    bit [RD_CH-1:0] rd_fv;
    int rd_fs [RD_CH];
    int rd_fl [RD_CH];

    function automatic logic [63:0] junk();
        return {$urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_reads();
        for (int c = 0; c < RD_CH; c++) begin
            bit v;
            int s;
            int l;
            exp_t e;
            v = 1'b0; s = 0; l = 0;
            if (rd_mode == 1) begin
                v = ($urandom_range(0, 1) == 1);
                s = $urandom_range(0, NUM_SEG - 1);
                l = $urandom_range(0, ENTRIES - 1);
            end else if (rd_mode == 2) begin
                v = rd_fv[c]; s = rd_fs[c]; l = rd_fl[c];
            end
            rd_valid[c] = v;
            rd_seg[c*SEG_W +: SEG_W] = SEG_W'(s);
            rd_sel[c*SEL_W +: SEL_W] = SEL_W'(l);
            if (v) begin
                e.miss = !ref_rdy[s];
                e.data = (e.miss || l == 0) ? '0 : ref_mem[s][l];
                for (int d = 0; d < 2; d++) begin
                    e.due = 32'(cyc + d + 1);
                    sb[d*RD_CH + c].push_back(e);
                end
            end
        end
    endtask

    // One clock: check load-side outputs from the previous edge, drive new inputs,
    // then advance the reference model to what the coming edge should produce.
    task automatic step(input bit st, input int sg, input bit v, input logic [LOAD_W-1:0] d);
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("ld_done[lat%0d]", u + 1), 64'(ld_done_w[u]), 64'(exp_done));
            chk($sformatf("ld_ready[lat%0d]", u + 1), 64'(ld_ready_w[u]), 64'(m_loading));
            chk($sformatf("tbl_ready[lat%0d]", u + 1), 64'(tbl_ready_w[u]), 64'(ref_rdy));
        end
        ld_start = st;
        ld_seg   = SEG_W'(sg);
        ld_valid = v;
        ld_data  = d;
        drive_reads();
        exp_done = 1'b0;
        if (st) begin
            m_loading   = 1'b1;
            m_seg       = sg;
            m_widx      = 0;
            ref_rdy[sg] = 1'b0;
        end else if (m_loading && v) begin
            m_buf[1 + m_widx / WPE][(m_widx % WPE)*LOAD_W +: LOAD_W] = d;
            m_widx++;
            if (m_widx == TOTAL) begin
                for (int k = 1; k < ENTRIES; k++) ref_mem[m_seg][k] = m_buf[k];
                ref_rdy[m_seg] = 1'b1;
                exp_done       = 1'b1;
                m_loading      = 1'b0;
            end
        end
    endtask

    task automatic rd_dir(input bit v0, input int s0, input int l0,
                          input bit v1, input int s1, input int l1);
        int saved;
        saved = rd_mode;
        rd_mode = 2;
        rd_fv = {v1, v0};
        rd_fs[0] = s0; rd_fl[0] = l0;
        rd_fs[1] = s1; rd_fl[1] = l1;
        step(1'b0, 0, 1'b0, junk());
        rd_mode = saved;
    endtask

    // Sends nwords of a segment load (TOTAL = complete). spec_pat selects the
    // byte-replicated entry pattern, otherwise random constants.
    task automatic do_load(input int seg, input int nwords, input bit gappy, input bit spec_pat);
        logic [DATA_W-1:0] ent [ENTRIES];
        logic [7:0] b;
        int w;
        bit toggle;
        int saved;
        for (int k = 1; k < ENTRIES; k++) begin
            if (spec_pat) begin
                b = k[7:0];
                ent[k] = {(DATA_W/8){b}};
            end else begin
                for (int j = 0; j < DATA_W/32; j++) ent[k][j*32 +: 32] = $urandom;
            end
        end
        // Start cycle also presents a word, which must be dropped.
        step(1'b1, seg, 1'b1, junk());
        w = 0;
        toggle = 1'b0;
        while (w < nwords) begin
            if (gappy && toggle) begin
                step(1'b0, seg, 1'b0, junk());
            end else begin
                saved = rd_mode;
                if (w == TOTAL - 1) begin
                    // Reads of this segment in the completing cycle must still miss.
                    rd_mode = 2; rd_fv = '1;
                    rd_fs[0] = seg; rd_fl[0] = 1;
                    rd_fs[1] = seg; rd_fl[1] = ENTRIES - 1;
                end
                step(1'b0, seg, 1'b1, ent[1 + w / WPE][(w % WPE)*LOAD_W +: LOAD_W]);
                rd_mode = saved;
                w++;
            end
            toggle = !toggle;
        end
        step(1'b0, seg, 1'b0, junk());
        step(1'b0, seg, 1'b0, junk());
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_rd_out_valid[lat%0d]", tag, u + 1), 64'(rd_out_valid_w[u]), 64'(0));
            chk($sformatf("%s_rd_miss[lat%0d]", tag, u + 1), 64'(rd_miss_w[u]), 64'(0));
            chk($sformatf("%s_rd_data_nonzero[lat%0d]", tag, u + 1), 64'(|rd_data_w[u]), 64'(0));
            chk($sformatf("%s_ld_ready[lat%0d]", tag, u + 1), 64'(ld_ready_w[u]), 64'(0));
            chk($sformatf("%s_ld_done[lat%0d]", tag, u + 1), 64'(ld_done_w[u]), 64'(0));
            chk($sformatf("%s_tbl_ready[lat%0d]", tag, u + 1), 64'(tbl_ready_w[u]), 64'(0));
        end
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        for (int q = 0; q < NQ; q++) sb[q].delete();
        ref_rdy   = '0;
        m_loading = 1'b0;
        exp_done  = 1'b0;
        ld_start  = 1'b0;
        ld_valid  = 1'b0;
        rd_valid  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Response monitor: pops and compares whenever a channel presents a result;
    // otherwise the output must hold the previous response data.
    logic [DATA_W-1:0] last_d [NQ];
    always @(negedge clk) begin : mon
        int q;
        int wi;
        exp_t e;
        logic [DATA_W-1:0] got;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < RD_CH; c++) begin
                q = d*RD_CH + c;
                got = rd_data_w[d][c*DATA_W +: DATA_W];
                if (!rst_n) begin
                    last_d[q] = '0;
                end else if (rd_out_valid_w[d][c]) begin
                    vectors++;
                    if (sb[q].size() == 0) begin
                        miscompares++;
                        $display("FAIL rd_unexpected lat%0d ch%0d cycle %0d: rd_out_valid=1, expected no response",
                                 d + 1, c, cyc);
                    end else begin
                        e = sb[q].pop_front();
                        wi = 0;
                        for (int k = DATA_W/64 - 1; k >= 0; k--)
                            if (got[k*64 +: 64] !== e.data[k*64 +: 64]) wi = k;
                        if (got !== e.data || rd_miss_w[d][c] !== e.miss || cyc != int'(e.due)) begin
                            miscompares++;
                            $display("FAIL rd_rsp lat%0d ch%0d cycle %0d: got miss=%0b word[%0d]=%h, expected miss=%0b word=%h at cycle %0d",
                                     d + 1, c, cyc, rd_miss_w[d][c], wi, got[wi*64 +: 64],
                                     e.miss, e.data[wi*64 +: 64], e.due);
                        end
                        last_d[q] = e.data;
                    end
                end else begin
                    vectors++;
                    if (got !== last_d[q]) begin
                        miscompares++;
                        $display("FAIL rd_hold lat%0d ch%0d cycle %0d: word0 %h, expected held %h",
                                 d + 1, c, cyc, got[63:0], last_d[q][63:0]);
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        rd_mode = 0;
        repeat (2) step(1'b0, 0, 1'b0, junk());

        // Back-to-back load of seg 0 with byte-pattern entries, random reads alongside
        rd_mode = 1;
        do_load(0, TOTAL, 1'b0, 1'b1);
        rd_mode = 0;
        step(1'b0, 0, 1'b0, junk());
        for (int u = 0; u < 2; u++)
            chk($sformatf("tbl_ready_seg0_only[lat%0d]", u + 1), 64'(tbl_ready_w[u]), 64'(4'b0001));
        rd_dir(1'b1, 0, 5, 1'b0, 0, 0);
        rd_dir(1'b1, 0, 0, 1'b1, 1, 3);
        repeat (3) step(1'b0, 0, 1'b0, junk());

        // Gapped loads: random seg 3, then seg 0 reloaded with the same pattern
        rd_mode = 1;
        do_load(3, TOTAL, 1'b1, 1'b0);
        do_load(0, TOTAL, 1'b1, 1'b1);
        rd_mode = 0;
        for (int l = 1; l < ENTRIES; l++) rd_dir(1'b1, 0, l, 1'b1, 3, l);

        // Abort a seg 1 load after 100 words, then a full seg 2 load
        rd_mode = 1;
        do_load(1, 100, 1'b0, 1'b0);
        do_load(2, TOTAL, 1'b0, 1'b0);
        rd_mode = 0;
        step(1'b0, 0, 1'b0, junk());
        for (int u = 0; u < 2; u++)
            chk($sformatf("tbl_ready_after_abort[lat%0d]", u + 1), 64'(tbl_ready_w[u][2:1]), 64'(2'b10));

        // Back-to-back bursts on both channels, no bubbles
        for (int l = 1; l < ENTRIES; l++) rd_dir(1'b1, 0, l, 1'b1, 2, l);
        for (int l = 1; l < ENTRIES; l++) rd_dir(1'b1, 1, l, 1'b1, 2, ENTRIES - l);

        rd_mode = 1;
        repeat (60) step(1'b0, 0, 1'b0, junk());

        // Reset in the middle of a seg 3 load with reads in flight
        step(1'b1, 3, 1'b1, junk());
        repeat (40) step(1'b0, 3, 1'b1, junk());
        do_reset_mid();
        rd_mode = 0;
        rd_dir(1'b1, 0, 7, 1'b1, 3, 1);
        rd_dir(1'b1, 2, 9, 1'b1, 0, 0);
        repeat (3) step(1'b0, 0, 1'b0, junk());

        // Reload seg 0 and read it back
        rd_mode = 1;
        do_load(0, TOTAL, 1'b0, 1'b1);
        rd_mode = 0;
        for (int l = 0; l < ENTRIES; l++) rd_dir(1'b1, 0, l, 1'b1, 1, l);
        repeat (4) step(1'b0, 0, 1'b0, junk());

        for (int q = 0; q < NQ; q++)
            chk($sformatf("outstanding_responses_q%0d", q), 64'(sb[q].size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
